// File: rtl/fantasy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fantasy_pkg
// Description : Shared types and constants for the mode controller.
// Revision    : 1.0  initial release
// ============================================================================
package fantasy_pkg;

    localparam int c_SW_WIDTH     = 4;
    localparam int c_SW_INV_LSB   = 0;
    localparam int c_SW_INV_MSB   = 1;
    localparam int c_SW_BYPASS    = 2;
    localparam int c_SW_FORCE_HPD = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_HPD_DROP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        INV_BLOCK   = 2'b00,
        INV_NONE    = 2'b01,
        INV_ALL     = 2'b10,
        INV_BLOCK_N = 2'b11
    } inv_mode_t;

    // Changing bypass or force-HPD must make the source re-read the sink.
    function automatic logic hpd_affecting_change(input logic [c_SW_WIDTH-1:0] a,
                                                  input logic [c_SW_WIDTH-1:0] b);
        return (a[c_SW_BYPASS] ^ b[c_SW_BYPASS]) |
               (a[c_SW_FORCE_HPD] ^ b[c_SW_FORCE_HPD]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : 2-flop synchronizer plus hold-time debounce for one switch.
// Revision    : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic deb_o
);

    localparam int c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_cnt  <= '0;
            deb_o  <= 1'b0;
        end else begin
            r_meta <= sw_i;
            r_sync <= r_meta;
            // Any return to the stable value restarts the hold window.
            if (r_sync == deb_o) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                deb_o <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mode_ctrl
// Description : Applies debounced switch configuration on vsync (or timeout)
//               and drops source HPD when bypass/force-HPD change.
// Revision    : 1.0  initial release
// ============================================================================
module mode_ctrl
    import fantasy_pkg::*;
#(
    parameter int DEB_CYCLES     = 1000000,
    parameter int HPD_LOW_CYCLES = 14850000,
    parameter int VS_TIMEOUT     = 4950000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [c_SW_WIDTH-1:0] sw_i,
    input  logic                  vs_i,
    input  logic                  vout_hpd_i,
    output logic [1:0]            inv_mode_o,
    output logic                  bypass_o,
    output logic                  vin_hpd_o,
    output logic                  applied_o,
    output logic                  vs_lost_o
);

    localparam int c_TO_W  = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
    localparam int c_HPD_W = (HPD_LOW_CYCLES > 1) ? $clog2(HPD_LOW_CYCLES) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = c_TO_W'(VS_TIMEOUT - 1);
    localparam logic [c_HPD_W-1:0] c_HPD_MAX = c_HPD_W'(HPD_LOW_CYCLES - 1);

    logic [c_SW_WIDTH-1:0] w_deb;
    logic [c_SW_WIDTH-1:0] r_applied;
    state_t                r_state;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic [c_HPD_W-1:0]    r_hpd_cnt;
    logic                  r_vs_meta;
    logic                  r_vs_sync;
    logic                  r_vs_prev;
    logic                  r_hpd_meta;
    logic                  r_hpd_sync;
    logic                  w_vs_rise;
    logic                  w_hpd_next;

    generate
        for (genvar gi = 0; gi < c_SW_WIDTH; gi++) begin : g_sw_deb
            sw_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_sw_debounce (
                .clk_i (clk_i),
                .rst_ni(rst_ni),
                .sw_i  (sw_i[gi]),
                .deb_o (w_deb[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vs_meta  <= 1'b0;
            r_vs_sync  <= 1'b0;
            r_vs_prev  <= 1'b0;
            r_hpd_meta <= 1'b0;
            r_hpd_sync <= 1'b0;
        end else begin
            r_vs_meta  <= vs_i;
            r_vs_sync  <= r_vs_meta;
            r_vs_prev  <= r_vs_sync;
            r_hpd_meta <= vout_hpd_i;
            r_hpd_sync <= r_hpd_meta;
        end
    end

    assign w_vs_rise  = r_vs_sync & ~r_vs_prev;
    assign w_hpd_next = r_hpd_sync | r_applied[c_SW_FORCE_HPD];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_applied <= '0;
            r_to_cnt  <= '0;
            r_hpd_cnt <= '0;
            vin_hpd_o <= 1'b0;
            applied_o <= 1'b0;
            vs_lost_o <= 1'b0;
        end else begin
            applied_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    vin_hpd_o <= w_hpd_next;
                    if (w_deb != r_applied) begin
                        r_state  <= ST_PENDING;
                        r_to_cnt <= '0;
                    end
                end
                ST_PENDING: begin
                    vin_hpd_o <= w_hpd_next;
                    if (w_deb == r_applied) begin
                        r_state <= ST_IDLE;
                    end else if (w_vs_rise || (r_to_cnt == c_TO_MAX)) begin
                        // A vs rise coinciding with expiry still counts as synchronized.
                        r_applied <= w_deb;
                        applied_o <= 1'b1;
                        vs_lost_o <= ~w_vs_rise;
                        if (hpd_affecting_change(r_applied, w_deb)) begin
                            r_state   <= ST_HPD_DROP;
                            r_hpd_cnt <= '0;
                            vin_hpd_o <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_HPD_DROP: begin
                    vin_hpd_o <= 1'b0;
                    if (r_hpd_cnt == c_HPD_MAX) begin
                        vin_hpd_o <= w_hpd_next;
                        if (w_deb != r_applied) begin
                            r_state  <= ST_PENDING;
                            r_to_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_hpd_cnt <= r_hpd_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign inv_mode_o = r_applied[c_SW_INV_MSB:c_SW_INV_LSB];
    assign bypass_o   = r_applied[c_SW_BYPASS];

endmodule
`default_nettype wire

// File: tb/tb_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_ctrl
// Description : Directed scoreboard bench for mode_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mode_ctrl;
    import fantasy_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] sw_i;
    logic       vs_i;
    logic       vout_hpd_i;
    logic [1:0] inv_mode_o;
    logic       bypass_o;
    logic       vin_hpd_o;
    logic       applied_o;
    logic       vs_lost_o;

    typedef struct packed {
        logic [1:0] inv;
        logic       byp;
        logic       lost;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mode_ctrl #(
        .DEB_CYCLES    (4),
        .HPD_LOW_CYCLES(8),
        .VS_TIMEOUT    (100)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sw_i      (sw_i),
        .vs_i      (vs_i),
        .vout_hpd_i(vout_hpd_i),
        .inv_mode_o(inv_mode_o),
        .bypass_o  (bypass_o),
        .vin_hpd_o (vin_hpd_o),
        .applied_o (applied_o),
        .vs_lost_o (vs_lost_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every applied_o pulse must match the oldest expected configuration.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && applied_o === 1'b1) begin
            n_checks++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_apply actual inv=%b byp=%b lost=%b required no pulse",
                         inv_mode_o, bypass_o, vs_lost_o);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                if ({inv_mode_o, bypass_o, vs_lost_o} !== e) begin
                    n_fail++;
                    $display("FAIL apply_value actual inv=%b byp=%b lost=%b required inv=%b byp=%b lost=%b",
                             inv_mode_o, bypass_o, vs_lost_o, e.inv, e.byp, e.lost);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;
        logic found;

        rst_ni = 1'b0; sw_i = 4'b0000; vs_i = 1'b0; vout_hpd_i = 1'b1;
        ticks(3);
        chk("reset_outputs", 32'({inv_mode_o, bypass_o, vin_hpd_o, applied_o, vs_lost_o}), 32'h0);
        chk("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst_ni = 1'b1;
        ticks(5);
        chk("hpd_follows_after_reset", 32'(vin_hpd_o), 32'h1);

        // Change then revert before any vs: must return to IDLE silently.
        sw_i = 4'b0001;
        ticks(8);
        chk("revert_pending", 32'(dut.r_state), 32'(ST_PENDING));
        sw_i = 4'b0000;
        ticks(10);
        chk("revert_idle", 32'(dut.r_state), 32'(ST_IDLE));
        chk("revert_inv", 32'(inv_mode_o), 32'h0);

        // Two-cycle glitch is swallowed by the debouncer.
        sw_i = 4'b0010;
        ticks(2);
        sw_i = 4'b0000;
        ticks(12);
        chk("glitch_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("glitch_deb", 32'(dut.w_deb), 32'h0);

        // vs-synchronized apply, output on the 3rd edge after vs rises.
        sw_i = 4'b0010;
        lows = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (!vin_hpd_o) lows++; end
        q_exp.push_back('{inv: 2'b10, byp: 1'b0, lost: 1'b0});
        vs_i = 1'b1;
        ticks(2);
        chk("vs_apply_not_early", 32'(inv_mode_o), 32'h0);
        tick();
        chk("vs_apply_3rd_edge", 32'(inv_mode_o), 32'h2);
        chk("vs_apply_pulse", 32'(applied_o), 32'h1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) vs_i = 1'b0;
            tick();
            if (!vin_hpd_o) lows++;
        end
        chk("vs_apply_hpd_kept", 32'(lows), 32'h0);

        // Bypass change with no vs: timeout apply, then HPD drop.
        sw_i = 4'b0110;
        q_exp.push_back('{inv: 2'b10, byp: 1'b1, lost: 1'b1});
        n = 0; found = 1'b0;
        while (!found && n < 200) begin
            tick(); n++;
            if (applied_o) found = 1'b1;
        end
        chk("timeout_latency", 32'(n), 32'd107);
        chk("timeout_bypass", 32'(bypass_o), 32'h1);
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (!vin_hpd_o) lows++;
        end
        chk("hpd_drop_low_cycles", 32'(lows), 32'd8);
        tick();
        chk("hpd_drop_release", 32'(vin_hpd_o), 32'h1);
        vout_hpd_i = 1'b0;
        ticks(3);
        chk("hpd_follow_low", 32'(vin_hpd_o), 32'h0);
        vout_hpd_i = 1'b1;
        ticks(3);
        chk("hpd_follow_high", 32'(vin_hpd_o), 32'h1);

        // vs rise coinciding with timeout expiry counts as synchronized.
        sw_i = 4'b0111;
        q_exp.push_back('{inv: 2'b11, byp: 1'b1, lost: 1'b0});
        ticks(104);
        chk("coincide_lost_before", 32'(vs_lost_o), 32'h1);
        vs_i = 1'b1;
        ticks(2);
        chk("coincide_not_early", 32'(applied_o), 32'h0);
        tick();
        chk("coincide_pulse", 32'(applied_o), 32'h1);
        chk("coincide_vs_lost", 32'(vs_lost_o), 32'h0);
        ticks(2);
        vs_i = 1'b0;
        ticks(6);

        // Reset in the middle of an HPD drop.
        sw_i = 4'b0011;
        ticks(10);
        q_exp.push_back('{inv: 2'b11, byp: 1'b0, lost: 1'b0});
        vs_i = 1'b1;
        ticks(3);
        chk("drop_apply_pulse", 32'(applied_o), 32'h1);
        vs_i = 1'b0;
        ticks(3);
        chk("drop_state", 32'(dut.r_state), 32'(ST_HPD_DROP));
        chk("drop_hpd_low", 32'(vin_hpd_o), 32'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({inv_mode_o, bypass_o, vin_hpd_o, applied_o, vs_lost_o}), 32'h0);
        sw_i = 4'b0000;
        ticks(3);
        chk("reset_hold_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst_ni = 1'b1;
        ticks(20);
        chk("post_reset_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("post_reset_cfg", 32'({inv_mode_o, bypass_o, vs_lost_o}), 32'h0);
        chk("post_reset_hpd", 32'(vin_hpd_o), 32'h1);

        chk("scoreboard_empty", 32'(q_exp.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
